// File: rtl/dm_arbiter.sv
// Round-robin two-port arbiter that sequences single data-memory accesses.
// Optional range/alignment check: define DM_ARB_ADDR_CHECK_EN.
module dm_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_BYTES = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_err,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_write,
    input  logic [DATA_W-1:0] mem_data_read,
    output logic              busy
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    logic [1:0]        state;
    logic              last;
    logic              win;
    logic              we_q;
    logic              pick;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_bad;
    logic [DATA_W-1:0] ld_data;

    // pick = 1 selects port 1; on a tie the port not granted last wins
    assign pick      = m1_req & (~m0_req | ~last);
    assign sel_we    = pick ? m1_we    : m0_we;
    assign sel_addr  = pick ? m1_addr  : m0_addr;
    assign sel_wdata = pick ? m1_wdata : m0_wdata;
    assign busy      = (state != IDLE);

`ifdef DM_ARB_ADDR_CHECK_EN
    logic bad_q;
    logic err_q;

    assign sel_bad = (sel_addr[1:0] != 2'b00) ||
                     (sel_addr > ADDR_W'(MEM_BYTES - 4));
    assign ld_data = bad_q ? '0 : mem_data_read;
    assign m0_err  = err_q & m0_ack;
    assign m1_err  = err_q & m1_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bad_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            if (state == IDLE && (m0_req || m1_req))
                bad_q <= sel_bad;
            err_q <= (state == ACCESS) && bad_q;
        end
    end
`else
    assign sel_bad = 1'b0;
    assign ld_data = mem_data_read;
    assign m0_err  = 1'b0;
    assign m1_err  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            last           <= 1'b1;
            win            <= 1'b0;
            we_q           <= 1'b0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            mem_address    <= '0;
            mem_data_write <= '0;
            m0_ack         <= 1'b0;
            m1_ack         <= 1'b0;
            m0_rdata       <= '0;
            m1_rdata       <= '0;
        end else begin
            m0_ack    <= 1'b0;
            m1_ack    <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        win            <= pick;
                        we_q           <= sel_we;
                        mem_address    <= sel_addr;
                        mem_data_write <= sel_wdata;
                        mem_read       <= ~sel_we & ~sel_bad;
                        mem_write      <= sel_we & ~sel_bad;
                        state          <= ACCESS;
                    end
                end
                ACCESS: begin
                    last  <= win;
                    state <= DONE;
                    if (win) m1_ack <= 1'b1;
                    else     m0_ack <= 1'b1;
                    if (!we_q) begin
                        if (win) m1_rdata <= ld_data;
                        else     m0_rdata <= ld_data;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter: memory model, ack scoreboard, strobe checks.
module tb_dm_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MB = 1024;

    typedef struct {
        logic          port;
        logic          we;
        logic [DW-1:0] rdata;
        logic          err;
        int            cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          m0_req, m0_we, m1_req, m1_we;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic          m0_ack, m1_ack, m0_err, m1_err;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          mem_read, mem_write, busy;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data_write;
    logic [DW-1:0] mem_data_read = '0;

    logic [7:0] mem [0:MB-1];
    exp_t       sb[$];
    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int rd_cnt = 0;
    int ack0_cnt = 0;
    int ack1_cnt = 0;
    int rem0 = 0;
    int rem1 = 0;
    int ma;

    always #5 clk = ~clk;

    dm_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_BYTES(MB)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .m1_err(m1_err),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_data_write(mem_data_write),
        .mem_data_read(mem_data_read), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rd_word(input int a);
        return {mem[a], mem[a+1], mem[a+2], mem[a+3]};
    endfunction

    // Big-endian byte memory: write and registered read on the falling edge
    always @(negedge clk) begin
        if (mem_address <= 32'(MB - 4)) begin
            ma = int'(mem_address[9:0]);
            if (mem_write) begin
                mem[ma]   = mem_data_write[31:24];
                mem[ma+1] = mem_data_write[23:16];
                mem[ma+2] = mem_data_write[15:8];
                mem[ma+3] = mem_data_write[7:0];
            end
            if (mem_read)
                mem_data_read <= rd_word(ma);
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1) begin
            if (mem_read) rd_cnt++;
            chk("strobe_onehot", 32'(mem_read & mem_write), 32'd0);
            if (m0_ack || m1_ack) begin
                chk("ack_onehot", 32'(m0_ack & m1_ack), 32'd0);
                if (sb.size() == 0) begin
                    chk("unexpected_ack", 32'({m1_ack, m0_ack}), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("ack_port", 32'(m1_ack), 32'(e.port));
                    chk("ack_err", 32'(m1_ack ? m1_err : m0_err),
                        32'(e.err));
                    if (!e.we)
                        chk("ack_rdata", m1_ack ? m1_rdata : m0_rdata,
                            e.rdata);
                    if (e.cyc >= 0)
                        chk("ack_cycle", 32'(cyc), 32'(e.cyc));
                end
                if (m0_ack) begin
                    ack0_cnt++;
                    if (rem0 > 0) rem0--;
                    if (rem0 == 0) m0_req = 1'b0;
                end
                if (m1_ack) begin
                    ack1_cnt++;
                    if (rem1 > 0) rem1--;
                    if (rem1 == 0) m1_req = 1'b0;
                end
            end
        end
    end

    task automatic expect_ack(input logic port, input logic we,
                              input logic [31:0] rdata, input logic err,
                              input int c);
        exp_t e;
        e.port = port; e.we = we; e.rdata = rdata; e.err = err; e.cyc = c;
        sb.push_back(e);
    endtask

    task automatic issue(input logic port, input logic we,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input int n);
        if (port) begin
            m1_we = we; m1_addr = addr; m1_wdata = wd; rem1 = n;
            m1_req = 1'b1;
        end else begin
            m0_we = we; m0_addr = addr; m0_wdata = wd; rem0 = n;
            m0_req = 1'b1;
        end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((sb.size() != 0 || busy || m0_req || m1_req) && n < 80) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(n < 80), 32'd1);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_rd"}, 32'(mem_read), 32'd0);
        chk({tag, "_wr"}, 32'(mem_write), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_acks"}, 32'({m1_ack, m0_ack}), 32'd0);
        chk({tag, "_errs"}, 32'({m1_err, m0_err}), 32'd0);
        chk({tag, "_addr"}, mem_address, 32'd0);
        chk({tag, "_wdata"}, mem_data_write, 32'd0);
        chk({tag, "_rdata0"}, m0_rdata, 32'd0);
        chk({tag, "_rdata1"}, m1_rdata, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int c;
        int r0;
        int a0;
        int a1;
        logic [31:0] w;
        rst_n = 1'b0;
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
        for (int i = 0; i < MB; i++) mem[i] = 8'h00;
        {mem[16], mem[17], mem[18], mem[19]} = 32'hDEADBEEF;
        {mem[1020], mem[1021], mem[1022], mem[1023]} = 32'hCAFEF00D;
        repeat (2) @(negedge clk);
        check_zero("reset");
        #1 rst_n = 1'b1;

        // single load, latency and strobe width
        @(negedge clk); #1;
        c = cyc; r0 = rd_cnt;
        expect_ack(1'b0, 1'b0, 32'hDEADBEEF, 1'b0, c + 2);
        issue(1'b0, 1'b0, 32'h10, 32'h0, 1);
        wait_idle("load_done");
        chk("load_rd_cycles", 32'(rd_cnt - r0), 32'd1);
        chk("load_rdata_held", m0_rdata, 32'hDEADBEEF);

        // store then load on port 1
        @(negedge clk); #1;
        expect_ack(1'b1, 1'b1, 32'h0, 1'b0, -1);
        issue(1'b1, 1'b1, 32'h20, 32'h12345678, 1);
        wait_idle("store_done");
        chk("store_byte20", 32'(mem[32]), 32'h12);
        chk("store_word20", rd_word(32), 32'h12345678);
        chk("store_keeps_rdata", m1_rdata, 32'h0);
        @(negedge clk); #1;
        expect_ack(1'b1, 1'b0, 32'h12345678, 1'b0, -1);
        issue(1'b1, 1'b0, 32'h20, 32'h0, 1);
        wait_idle("reload_done");

        // tie from reset: alternation m0, m1, m0, m1 three cycles apart
        @(negedge clk); #1 rst_n = 1'b0;
        @(negedge clk); #1 rst_n = 1'b1;
        @(negedge clk); #1;
        c = cyc;
        expect_ack(1'b0, 1'b0, 32'hDEADBEEF, 1'b0, c + 2);
        expect_ack(1'b1, 1'b0, 32'h12345678, 1'b0, c + 5);
        expect_ack(1'b0, 1'b0, 32'hDEADBEEF, 1'b0, c + 8);
        expect_ack(1'b1, 1'b0, 32'h12345678, 1'b0, c + 11);
        issue(1'b0, 1'b0, 32'h10, 32'h0, 2);
        issue(1'b1, 1'b0, 32'h20, 32'h0, 2);
        wait_idle("tie_done");

        // reset during ACCESS of a store, before the falling edge
        @(negedge clk); #1;
        w = rd_word(64);
        a0 = ack0_cnt;
        issue(1'b0, 1'b1, 32'h40, 32'hA5A5A5A5, 1);
        @(posedge clk); #1;
        chk("mid_wr_strobe", 32'(mem_write), 32'd1);
        rst_n = 1'b0;
        #1;
        check_zero("midrst");
        m0_req = 1'b0;
        @(negedge clk); #1 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("midrst_no_ack", 32'(ack0_cnt), 32'(a0));
        chk("midrst_mem40", rd_word(64), w);

        // aligned in-range load at the top of memory
        @(negedge clk); #1;
        expect_ack(1'b0, 1'b0, 32'hCAFEF00D, 1'b0, -1);
        issue(1'b0, 1'b0, 32'h3FC, 32'h0, 1);
        wait_idle("top_load_done");
`ifdef DM_ARB_ADDR_CHECK_EN
        r0 = rd_cnt;
        @(negedge clk); #1;
        expect_ack(1'b0, 1'b0, 32'h0, 1'b1, -1);
        issue(1'b0, 1'b0, 32'h3FE, 32'h0, 1);
        wait_idle("misalign_done");
        @(negedge clk); #1;
        expect_ack(1'b0, 1'b0, 32'h0, 1'b1, -1);
        issue(1'b0, 1'b0, 32'h400, 32'h0, 1);
        wait_idle("range_done");
        chk("bad_no_strobe", 32'(rd_cnt - r0), 32'd0);
`endif

        // withdrawal: m1 pulses while m0 is in ACCESS
        @(negedge clk); #1;
        a1 = ack1_cnt;
        expect_ack(1'b0, 1'b0, 32'hDEADBEEF, 1'b0, -1);
        issue(1'b0, 1'b0, 32'h10, 32'h0, 1);
        @(posedge clk); #1;
        m1_we = 1'b0; m1_addr = 32'h20;
        m1_req = 1'b1;
        #2 m1_req = 1'b0;
        wait_idle("withdraw_done");
        repeat (3) @(negedge clk);
        chk("withdraw_no_ack", 32'(ack1_cnt), 32'(a1));
        chk("withdraw_busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
